// File: rtl/audio_route_ctrl_if.sv
// Bundle between the source filters/codec side and audio_route_ctrl.
// The "master" modport is the environment (sources, selector, codec); "slave" is the router.
interface audio_route_ctrl_if #(
  parameter int DATA_SIZE = 24,
  parameter int NCH       = 4
);
  localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1;

  // Handshake: ch_valid[k] is a one-cycle strobe meaning ch_data channel k holds a new
  // filtered sample. dac_ready high at a rising edge means the codec accepts dac_data,
  // so the router loads its next value on that edge and holds dac_data otherwise.
  // sample and stale are single-cycle strobes. dbg_state: 0 RUN, 1 FADE_OUT, 2 SWAP,
  // 3 FADE_IN, and constant 0 when the fade FSM is not built.
  logic [NCH*DATA_SIZE-1:0] ch_data;
  logic [NCH-1:0]           ch_valid;
  logic [SELW-1:0]          sel;
  logic                     dac_ready;
  logic                     sample;
  logic [DATA_SIZE-1:0]     dac_data;
  logic [SELW-1:0]          cur_sel;
  logic                     busy;
  logic                     stale;
  logic                     sel_err;
  logic [1:0]               dbg_state;

  modport master (
    output ch_data, ch_valid, sel, dac_ready,
    input  sample, dac_data, cur_sel, busy, stale, sel_err, dbg_state
  );

  modport slave (
    input  ch_data, ch_valid, sel, dac_ready,
    output sample, dac_data, cur_sel, busy, stale, sel_err, dbg_state
  );
endinterface

// File: rtl/audio_route_ctrl.sv
// Sample-rate router: picks one of NCH captured sources per sample strobe and feeds the codec.
// Define ROUTE_SOFT_SWITCH_EN to build the fade-out/swap/fade-in FSM; otherwise switches are instant.
module audio_route_ctrl #(
  parameter int DATA_SIZE  = 24,
  parameter int NCH        = 4,
  parameter int DIV        = 5000,
  parameter int RAMP_STEPS = 8
) (
  input logic               clk,
  input logic               reset,
  audio_route_ctrl_if.slave bus
);
  localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW   = $clog2(DIV);
  localparam int ATTW = $clog2(RAMP_STEPS + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DIV - 1);
  localparam logic [ATTW-1:0] ATT_MAX = ATTW'(RAMP_STEPS);
  localparam logic [SELW:0]   NCH_W   = (SELW + 1)'(NCH);

  logic [CW-1:0]        r_cnt;
  logic [DATA_SIZE-1:0] r_cap [NCH];
  logic [DATA_SIZE-1:0] r_y;
  logic [DATA_SIZE-1:0] r_dac;
  logic [SELW-1:0]      r_cur_sel;
  logic                 r_seen;
  logic                 r_stale;

  logic                 w_sample;
  logic                 w_sel_ok;
  logic                 w_sel_diff;
  logic [ATTW-1:0]      w_att_next;
  logic                 w_swap;
  logic                 w_cur_we;
  logic [SELW-1:0]      w_load_sel;
  logic [DATA_SIZE-1:0] w_src;
  logic [DATA_SIZE-1:0] w_y_next;
  logic                 w_busy;
  logic [1:0]           w_dbg_state;

  assign w_sample   = (r_cnt == CNT_MAX);
  assign w_sel_ok   = ({1'b0, bus.sel} < NCH_W);
  assign w_sel_diff = w_sel_ok && (bus.sel != r_cur_sel);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_cnt <= '0;
    else if (w_sample) r_cnt <= '0;
    else               r_cnt <= r_cnt + CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NCH; k++) r_cap[k] <= '0;
    end else begin
      for (int k = 0; k < NCH; k++)
        if (bus.ch_valid[k]) r_cap[k] <= bus.ch_data[k*DATA_SIZE +: DATA_SIZE];
    end
  end

`ifdef ROUTE_SOFT_SWITCH_EN
  typedef enum logic [1:0] {RUN = 2'd0, FADE_OUT = 2'd1, SWAP = 2'd2, FADE_IN = 2'd3} state_t;
  localparam logic [ATTW-1:0] ATT_ONE = ATTW'(1);

  state_t          r_state;
  state_t          w_state_next;
  logic [ATTW-1:0] r_att;
  logic            r_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RUN;
      r_att   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next != RUN);
      if (w_sample) r_att <= w_att_next;
    end
  end

  // w_att_next is the attenuation applied to the y_reg load of this sample.
  always_comb begin
    w_state_next = r_state;
    w_att_next   = r_att;
    w_swap       = 1'b0;
    case (r_state)
      RUN:      if (w_sample && w_sel_diff) w_state_next = FADE_OUT;
      FADE_OUT: if (w_sample) begin
                  w_att_next = r_att + ATT_ONE;
                  if (w_att_next == ATT_MAX) w_state_next = SWAP;
                end
      SWAP:     begin
                  w_swap       = 1'b1;
                  w_state_next = FADE_IN;
                end
      FADE_IN:  if (w_sample) begin
                  w_att_next = r_att - ATT_ONE;
                  if (w_att_next == '0) w_state_next = RUN;
                end
      default:  w_state_next = RUN;
    endcase
  end

  assign w_cur_we    = w_swap && w_sel_ok;
  assign w_load_sel  = r_cur_sel;
  assign w_busy      = r_busy;
  assign w_dbg_state = r_state;
`else
  // Hard switch: the new channel is routed by the very sample that notices the change.
  assign w_att_next  = '0;
  assign w_swap      = 1'b0;
  assign w_cur_we    = w_sample && w_sel_diff;
  assign w_load_sel  = w_cur_we ? bus.sel : r_cur_sel;
  assign w_busy      = 1'b0;
  assign w_dbg_state = 2'd0;
`endif

  assign w_src = r_cap[w_load_sel];

  always_comb begin
    w_y_next = $signed(w_src) >>> w_att_next;
    if (w_att_next == ATT_MAX) w_y_next = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_y       <= '0;
      r_dac     <= '0;
      r_cur_sel <= '0;
      r_seen    <= 1'b0;
      r_stale   <= 1'b0;
    end else begin
      r_stale <= 1'b0;
      if (bus.dac_ready) r_dac <= r_y;
      if (w_cur_we) r_cur_sel <= bus.sel;
      // A strobe landing on the sample cycle counts for neither period's tracking.
      if (w_sample) begin
        r_y     <= w_y_next;
        r_stale <= !r_seen;
        r_seen  <= 1'b0;
      end else if (w_swap) begin
        r_seen <= 1'b0;
      end else if (bus.ch_valid[r_cur_sel]) begin
        r_seen <= 1'b1;
      end
    end
  end

  assign bus.sample    = w_sample;
  assign bus.dac_data  = r_dac;
  assign bus.cur_sel   = r_cur_sel;
  assign bus.busy      = w_busy;
  assign bus.stale     = r_stale;
  assign bus.sel_err   = !w_sel_ok;
  assign bus.dbg_state = w_dbg_state;
endmodule
